// File: rtl/pid_seq_pkg.sv
// Shared types and constants for the servo control-loop sequencer.
package pid_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SAMPLE    = 3'd1,
    ST_WAIT_ADC  = 3'd2,
    ST_START     = 3'd3,
    ST_WAIT_PID  = 3'd4,
    ST_WAIT_SYNC = 3'd5
  } state_e;

  // Shortest loop period; covers a zero-wait iteration so it can never overrun.
  localparam int unsigned MIN_PERIOD = 8;
  localparam int unsigned OVR_CNT_W  = 8;

  // Increment that sticks at all-ones.
  function automatic logic [OVR_CNT_W-1:0] sat_inc_ovr(input logic [OVR_CNT_W-1:0] v);
    return (v == {OVR_CNT_W{1'b1}}) ? v : v + OVR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/loop_tick_gen.sv
// Loop-period tick generator: counts 0..P-1, P = max(period_i, MIN_PERIOD).
module loop_tick_gen
  import pid_seq_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             reset,
  input  logic             enable_i,
  input  logic [DIV_W-1:0] period_i,
  output logic             tick_o
);

  localparam logic [DIV_W-1:0] MIN_P = DIV_W'(MIN_PERIOD);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] per_q, per_d;
  logic [DIV_W-1:0] per_clamp;
  logic             tick_q, tick_d;

  // Next count and period; the period is re-sampled at each wrap and tracks
  // period_i while disabled so the first period after enable is the requested one.
  always_comb begin
    per_clamp = (period_i < MIN_P) ? MIN_P : period_i;
    cnt_d     = cnt_q;
    per_d     = per_q;
    tick_d    = 1'b0;
    if (!enable_i) begin
      cnt_d = '0;
      per_d = per_clamp;
    end else if (cnt_q == per_q - DIV_W'(1)) begin
      cnt_d  = '0;
      per_d  = per_clamp;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  // Counter, period and tick registers.
  always_ff @(posedge clk_i) begin
    if (!reset) begin
      cnt_q  <= '0;
      per_q  <= MIN_P;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/pid_loop_sequencer.sv
// Control-loop sequencer: tick -> ADC sample -> PID compute -> duty load at PWM sync.
module pid_loop_sequencer
  import pid_seq_pkg::*;
#(
  parameter int unsigned      WIDTH    = 12,
  parameter int unsigned      DIV_W    = 16,
  parameter int unsigned      TIMEOUT  = 255,
  parameter logic [WIDTH-1:0] DUTY_RST = '0
) (
  input  logic                 clk_i,
  input  logic                 reset,
  input  logic                 enable_i,
  input  logic                 clr_i,
  input  logic [DIV_W-1:0]     period_i,
  output logic                 adc_req_o,
  input  logic                 adc_valid_i,
  input  logic [WIDTH-1:0]     adc_data_i,
  output logic [WIDTH-1:0]     pid_y_o,
  output logic                 pid_start_o,
  input  logic                 pid_done_i,
  input  logic [WIDTH-1:0]     pid_u_i,
  input  logic                 pwm_sync_i,
  output logic [WIDTH-1:0]     pwm_duty_o,
  output logic                 pwm_load_o,
  output logic                 busy_o,
  output logic                 overrun_o,
  output logic                 fault_o,
  output logic [OVR_CNT_W-1:0] overrun_cnt_o
);

  // Wait counter holds 0..TIMEOUT-1; the last value is the give-up point.
  localparam int unsigned      WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [WIDTH-1:0]       pid_y_q, pid_y_d;
  logic [WIDTH-1:0]       pend_q, pend_d;
  logic [WIDTH-1:0]       duty_q, duty_d;
  logic                   adc_req_q, adc_req_d;
  logic                   pid_start_q, pid_start_d;
  logic                   load_q, load_d;
  logic                   busy_q, busy_d;
  logic                   ovr_q, ovr_d;
  logic                   fault_q, fault_d;
  logic [OVR_CNT_W-1:0]   ovr_cnt_q, ovr_cnt_d;
  logic                   tick;
  logic                   ovr_ev;
  logic                   fault_ev;

  loop_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk_i    (clk_i),
    .reset    (reset),
    .enable_i (enable_i),
    .period_i (period_i),
    .tick_o   (tick)
  );

  // Next-state, datapath latches, flags and registered strobes.
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    pid_y_d   = pid_y_q;
    pend_d    = pend_q;
    duty_d    = duty_q;
    load_d    = 1'b0;
    fault_ev  = 1'b0;
    ovr_d     = ovr_q;
    fault_d   = fault_q;
    ovr_cnt_d = ovr_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (tick) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: state_d = ST_WAIT_ADC;
      ST_WAIT_ADC: begin
        if (adc_valid_i) begin
          pid_y_d = adc_data_i;
          state_d = ST_START;
        end else if (wait_q == WAIT_LAST) begin
          fault_ev = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_START: state_d = ST_WAIT_PID;
      ST_WAIT_PID: begin
        if (pid_done_i) begin
          pend_d  = pid_u_i;
          state_d = ST_WAIT_SYNC;
        end else if (wait_q == WAIT_LAST) begin
          fault_ev = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_WAIT_SYNC: begin
        if (pwm_sync_i) begin
          duty_d  = pend_q;
          load_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A tick that finds the loop busy is dropped and recorded; set beats clear.
    ovr_ev = tick && (state_q != ST_IDLE);
    if (ovr_ev) begin
      ovr_d     = 1'b1;
      ovr_cnt_d = clr_i ? OVR_CNT_W'(1) : sat_inc_ovr(ovr_cnt_q);
    end else if (clr_i) begin
      ovr_d     = 1'b0;
      ovr_cnt_d = '0;
    end

    if (fault_ev)   fault_d = 1'b1;
    else if (clr_i) fault_d = 1'b0;

    adc_req_d   = (state_d == ST_SAMPLE);
    pid_start_d = (state_d == ST_START);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      pid_y_q     <= '0;
      pend_q      <= DUTY_RST;
      duty_q      <= DUTY_RST;
      adc_req_q   <= 1'b0;
      pid_start_q <= 1'b0;
      load_q      <= 1'b0;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
      fault_q     <= 1'b0;
      ovr_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      pid_y_q     <= pid_y_d;
      pend_q      <= pend_d;
      duty_q      <= duty_d;
      adc_req_q   <= adc_req_d;
      pid_start_q <= pid_start_d;
      load_q      <= load_d;
      busy_q      <= busy_d;
      ovr_q       <= ovr_d;
      fault_q     <= fault_d;
      ovr_cnt_q   <= ovr_cnt_d;
    end
  end

  assign adc_req_o     = adc_req_q;
  assign pid_start_o   = pid_start_q;
  assign pid_y_o       = pid_y_q;
  assign pwm_duty_o    = duty_q;
  assign pwm_load_o    = load_q;
  assign busy_o        = busy_q;
  assign overrun_o     = ovr_q;
  assign fault_o       = fault_q;
  assign overrun_cnt_o = ovr_cnt_q;

endmodule
